cv_7seg_x8: RTL and testbench

- Time-multiplexed driver for an 8-digit common-anode 7-segment display.
- Scans one digit at a time, stepping to the next digit on each CE strobe.
- Converts the selected 4-bit nibble of HEX_IN to a hex glyph and adds its decimal point.
- Suppresses any digit flagged in BLANK.
- Sits between the numeric datapath and the board's anode/cathode pins.

---
 rtl/cv_7seg_x8.sv | 89 ++++++++
 tb/tb_cv_7seg_x8.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cv_7seg_x8.sv
// cv_7seg_x8: time-multiplexed driver for an 8-digit common-anode
// 7-segment display. A 3-bit scan index steps on each CE strobe; the
// anode/cathode registers reload every clock from the current index and
// live inputs, so the pins lag the index and the inputs by one cycle.
// All outputs are active-low. A blanked digit drives neither its anode
// nor any cathode.

module cv_7seg_x8 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [31:0] HEX_IN,
  input  logic [7:0]  DP_IN,
  input  logic [7:0]  BLANK,
  output logic [7:0]  AN,
  output logic [7:0]  CAT
);

  logic [2:0] idx_q, idx_d;
  logic [7:0] an_q, an_d;
  logic [7:0] cat_q, cat_d;
  logic [3:0] nibble;
  logic [6:0] seg;

  // Scan index: advance on CE, wrap 7 -> 0 through natural 3-bit overflow.
  always_comb begin
    idx_d = idx_q;
    if (CE) begin
      idx_d = idx_q + 3'd1;
    end
  end

  // Pick the nibble of the digit currently being scanned.
  always_comb begin
    nibble = HEX_IN[{idx_q, 2'b00} +: 4];
  end

  // Hex glyph decode, active-high, bit order gfedcba.
  always_comb begin
    seg = 7'h00;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  // Next pin values: everything off for a blanked digit, else one anode low
  // and the inverted glyph plus decimal point on the cathodes.
  always_comb begin
    an_d  = 8'hFF;
    cat_d = 8'hFF;
    if (!BLANK[idx_q]) begin
      an_d  = ~(8'b1 << idx_q);
      cat_d = {~DP_IN[idx_q], ~seg};
    end
  end

  // Index and output registers; async reset forces the display dark.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q <= 3'd0;
      an_q  <= 8'hFF;
      cat_q <= 8'hFF;
    end else begin
      idx_q <= idx_d;
      an_q  <= an_d;
      cat_q <= cat_d;
    end
  end

  assign AN  = an_q;
  assign CAT = cat_q;

endmodule

// File: tb/tb_cv_7seg_x8.sv
// Testbench for cv_7seg_x8: a scan-position model (CE pulses counted since
// reset) predicts the pins every cycle; directed scenarios add literal
// expectations computed by hand.

module tb_cv_7seg_x8;

  logic        CLK;
  logic        RST;
  logic        CE;
  logic [31:0] HEX_IN;
  logic [7:0]  DP_IN;
  logic [7:0]  BLANK;
  logic [7:0]  AN;
  logic [7:0]  CAT;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  logic [6:0] glyph [16];
  logic [7:0] s1_an  [8];
  logic [7:0] s1_cat [8];

  int         m_pos;
  logic [7:0] m_an;
  logic [7:0] m_cat;

  cv_7seg_x8 dut (
    .CLK    (CLK),
    .RST    (RST),
    .CE     (CE),
    .HEX_IN (HEX_IN),
    .DP_IN  (DP_IN),
    .BLANK  (BLANK),
    .AN     (AN),
    .CAT    (CAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Model: position = CE pulses since reset, mod 8; pins built from the
  // inputs present just before the edge.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pos = 0;
      m_an  = 8'hFF;
      m_cat = 8'hFF;
    end else begin
      int k;
      int nib;
      k = m_pos % 8;
      if (BLANK[k]) begin
        m_an  = 8'hFF;
        m_cat = 8'hFF;
      end else begin
        nib   = int'((HEX_IN >> (4 * k)) & 32'hF);
        m_an  = 8'(255 - (1 << k));
        m_cat = 8'(255 - (DP_IN[k] ? 128 : 0) - int'(glyph[nib]));
      end
      if (CE) m_pos = m_pos + 1;
    end
  end

  // Compare the pins against the model on every falling edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_an", AN, m_an);
      check("model_cat", CAT, m_cat);
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
    glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
    glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
    glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
    s1_an[0] = 8'hFE; s1_an[1] = 8'hFD; s1_an[2] = 8'hFB; s1_an[3] = 8'hF7;
    s1_an[4] = 8'hEF; s1_an[5] = 8'hDF; s1_an[6] = 8'hBF; s1_an[7] = 8'h7F;
    s1_cat[0] = 8'hA4; s1_cat[1] = 8'h90; s1_cat[2] = 8'h78; s1_cat[3] = 8'h88;
    s1_cat[4] = 8'h24; s1_cat[5] = 8'h30; s1_cat[6] = 8'h46; s1_cat[7] = 8'h90;

    // 1: reset and scan sequence
    RST    = 1'b1;
    CE     = 1'b1;
    HEX_IN = 32'h9C32A792;
    DP_IN  = 8'h74;
    BLANK  = 8'h00;
    @(negedge CLK);
    chk_en = 1'b1;
    repeat (9) @(negedge CLK);
    check("s1_reset_an", AN, 8'hFF);
    check("s1_reset_cat", CAT, 8'hFF);
    #1 RST = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      check("s1_scan_an", AN, s1_an[i % 8]);
      check("s1_scan_cat", CAT, s1_cat[i % 8]);
    end

    // 2a: leading-blank ramp, shifting a 0 into BLANK each CE
    BLANK = 8'hFE;
    do_reset();
    @(negedge CLK);
    check("s2_digit0_an", AN, 8'hFE);
    check("s2_digit0_cat", CAT, 8'hA4);
    for (int i = 0; i < 10; i++) begin
      BLANK = BLANK << 1;
      @(negedge CLK);
    end

    // 2b: fixed blanking of the upper four digits
    BLANK = 8'hF0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 3) check("s2b_digit3_an", AN, 8'hF7);
      if (i == 4) begin
        check("s2b_digit4_an", AN, 8'hFF);
        check("s2b_digit4_cat", CAT, 8'hFF);
      end
    end
    BLANK = 8'h00;

    // 3: CE gating at idx 3
    do_reset();
    repeat (3) @(negedge CLK);
    CE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("s3_hold_an", AN, 8'hF7);
      check("s3_hold_cat", CAT, 8'h88);
    end
    HEX_IN = 32'h9C32F792;
    @(negedge CLK);
    check("s3_live_an", AN, 8'hF7);
    check("s3_live_cat", CAT, 8'h8E);
    CE = 1'b1;

    // 4: all sixteen glyphs
    HEX_IN = 32'h76543210;
    DP_IN  = 8'h00;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 0) check("s4_glyph0", CAT, 8'hC0);
      if (i == 7) check("s4_glyph7", CAT, 8'hF8);
    end
    HEX_IN = 32'hFEDCBA98;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 0) check("s4_glyph8", CAT, 8'h80);
      if (i == 2) check("s4_glyphA", CAT, 8'h88);
      if (i == 7) check("s4_glyphF", CAT, 8'h8E);
    end

    // 5: async reset mid-scan at idx 5
    HEX_IN = 32'h9C32A792;
    DP_IN  = 8'h74;
    do_reset();
    repeat (5) @(negedge CLK);
    check("s5_pre_an", AN, 8'hEF);
    #2 RST = 1'b1;
    #1;
    check("s5_async_an", AN, 8'hFF);
    check("s5_async_cat", CAT, 8'hFF);
    @(negedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("s5_restart_an", AN, 8'hFE);
    check("s5_restart_cat", CAT, 8'hA4);

    // 6: full blank with every DP requested
    BLANK = 8'hFF;
    DP_IN = 8'hFF;
    @(negedge CLK);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      check("s6_blank_an", AN, 8'hFF);
      check("s6_blank_cat", CAT, 8'hFF);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
